// File: rtl/mem_ctrl_4x4.sv
// mem_ctrl_4x4: request-side front end for a 4x4 synchronous RAM.
// It clears every RAM location after reset, then serves single-beat
// read/write requests over a valid/ready handshake.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_we/addr/wdata  request: 1 = write, 0 = read
//   rsp_valid/data     one-cycle read-result pulse, data held until next pulse
//   init_done          high once the post-reset clear has finished
//   mem_addr/we/din    registered RAM pins
//   mem_dout           RAM registered read data
module mem_ctrl_4x4 #(
    parameter int AW = 2,
    parameter int DW = 4,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          init_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    localparam int DEPTH = 2 ** AW;
    typedef enum logic [1:0] {INIT, IDLE, RD1, RD2} state_t;
    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          w_accept;
    logic          w_clr_last;
    assign req_ready  = (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    // The last clear write is already on the pins; leave INIT on the edge
    // that lets the RAM commit it.
    assign w_clr_last = mem_we && (mem_addr == AW'(DEPTH - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= INIT;
            r_cnt     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                INIT: begin
                    if (w_clr_last) begin
                        mem_we    <= 1'b0;
                        init_done <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= r_cnt;
                        mem_din  <= INIT_VAL;
                        if (r_cnt != AW'(DEPTH - 1)) r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    mem_we <= w_accept && req_we;
                    if (w_accept) begin
                        mem_addr <= req_addr;
                        if (req_we) mem_din <= req_wdata;
                        else r_state <= RD1;
                    end
                end
                RD1: r_state <= RD2;
                RD2: begin
                    rsp_data  <= mem_dout;
                    rsp_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_4x4.sv
// tb_mem_ctrl_4x4: randomized self-checking bench for mem_ctrl_4x4.
module tb_mem_ctrl_4x4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [1:0] req_addr = '0;
    logic [3:0] req_wdata = '0;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       init_done;
    logic [1:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_din;
    logic [3:0] mem_dout;

    mem_ctrl_4x4 dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Stand-in for the 4x4 RAM the controller drives.
    logic [3:0] ram [4];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        else mem_dout <= ram[mem_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: what the RAM should hold, how many edges of the
    // clear have elapsed, and how many edges until a pending read returns.
    logic [3:0] ref_mem [4];
    int         init_edge;
    int         rd_left;
    logic [3:0] pend;
    logic       e_rv;
    logic [3:0] e_data;
    logic       e_we;
    logic [1:0] e_addr;
    logic [3:0] e_din;

    function automatic logic m_ready();
        return init_edge == 5 && rd_left == 0;
    endfunction

    task automatic m_reset();
        init_edge = 0;
        rd_left = 0;
        e_rv = 0;
        e_data = 0;
        e_we = 0;
        e_addr = 0;
        e_din = 0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'h0;
    endtask

    task automatic check_outs();
        check("req_ready", req_ready, m_ready());
        check("init_done", init_done, init_edge == 5);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_data", rsp_data, e_data);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_din", mem_din, e_din);
    endtask

    // Drive one request cycle, predict the edge, then check after it.
    task automatic tick(input logic v, input logic we, input logic [1:0] a,
                        input logic [3:0] d, output logic acc);
        req_valid = v;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        acc = v && m_ready();
        e_rv = 0;
        if (init_edge < 5) begin
            init_edge++;
            e_we = init_edge <= 4;
            if (init_edge <= 4) begin
                e_addr = 2'(init_edge - 1);
                e_din = 4'h0;
            end
        end else if (rd_left > 0) begin
            rd_left--;
            e_we = 0;
            if (rd_left == 0) begin
                e_rv = 1;
                e_data = pend;
            end
        end else if (acc) begin
            e_addr = a;
            e_we = we;
            if (we) begin
                e_din = d;
                ref_mem[a] = d;
            end else begin
                rd_left = 2;
                pend = ref_mem[a];
            end
        end else e_we = 0;
        @(negedge clk);
        check_outs();
    endtask

    task automatic do_reset();
        rst = 1;
        req_valid = 0;
        m_reset();
        #1;
        check_outs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic until_acc(input logic we, input logic [1:0] a, input logic [3:0] d);
        logic acc;
        int k = 0;
        do begin
            tick(1, we, a, d, acc);
            k++;
        end while (!acc && k < 12);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    initial begin
        logic acc;
        logic [3:0] wv [4];
        m_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, acc);
        for (int i = 0; i < 4; i++) until_acc(0, 2'(i), 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, acc);
        // Request held during the clear must wait for IDLE.
        do_reset();
        until_acc(1, 2'd1, 4'h7);
        wv[0] = 4'h3; wv[1] = 4'hA; wv[2] = 4'h5; wv[3] = 4'hF;
        for (int i = 0; i < 4; i++) until_acc(1, 2'(i), wv[i]);
        for (int i = 0; i < 4; i++) until_acc(0, 2'(i), 0);
        until_acc(1, 2'd2, 4'h9);
        until_acc(0, 2'd2, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, acc);
        for (int i = 0; i < 10; i++) tick(1, 0, 2'd3, 0, acc);
        // Abort a read in RD1.
        until_acc(0, 2'd1, 0);
        do_reset();
        for (int i = 0; i < 400; i++)
            tick($urandom_range(3) != 0, $urandom_range(1) == 1,
                 2'($urandom_range(3)), 4'($urandom_range(15)), acc);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, acc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
